// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: PC source codes,
// forwarding-mux codes, controller state encoding and the zero register.
package pipe_pkg;

    // PC source select
    localparam logic [1:0] PC_SEL_PC4 = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    // EX operand forwarding select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register $zero never carries a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wait-tracking state: RUN = 0, HOLD = 1
    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: add one unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stage enables,
// flushes, PC source, EX forwarding, memory-wait watchdog and perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       FD_RS,
    input  logic [4:0]       FD_RT,
    input  logic             FD_use_rt,
    input  logic [4:0]       DX_RS,
    input  logic [4:0]       DX_RT,
    input  logic [4:0]       DX_RD,
    input  logic             DX_MemRead,
    input  logic             DX_jump,
    input  logic [4:0]       XM_RD,
    input  logic             XM_RegWrite,
    input  logic             XM_branch,
    input  logic [4:0]       MW_RD,
    input  logic             MW_RegWrite,
    input  logic             mem_wait,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             mw_we,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic [1:0]       pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cnt_ldstall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_wait
);

    logic      ld_hazard;
    logic      take_br;
    logic      take_jmp;
    logic      take_ld;
    logic [7:0] wait_inc;

    hz_state_e  state_q;
    logic [7:0] wait_run_q;
    logic       timeout_err_q;

    // Hazard detection and priority: mem_wait > branch > jump > load-use
    always_comb begin
        ld_hazard = DX_MemRead && (DX_RD != REG_ZERO) &&
                    ((DX_RD == FD_RS) || (FD_use_rt && (DX_RD == FD_RT)));
        take_br   = !mem_wait && XM_branch;
        take_jmp  = !mem_wait && !XM_branch && DX_jump;
        take_ld   = !mem_wait && !XM_branch && !DX_jump && ld_hazard;
    end

    // Stage enables, flushes and PC source from the resolved hazard
    always_comb begin
        pc_we    = 1'b1;
        fd_we    = 1'b1;
        dx_we    = 1'b1;
        xm_we    = 1'b1;
        mw_we    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        pc_sel   = PC_SEL_PC4;
        if (rst) begin
            pc_we = 1'b0;
            fd_we = 1'b0;
            dx_we = 1'b0;
            xm_we = 1'b0;
            mw_we = 1'b0;
        end else if (mem_wait) begin
            // Freeze: redirects stay pending in the frozen XM/DX registers
            pc_we = 1'b0;
            fd_we = 1'b0;
            dx_we = 1'b0;
            xm_we = 1'b0;
            mw_we = 1'b0;
        end else if (take_br) begin
            pc_sel   = PC_SEL_BR;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            xm_flush = 1'b1;
        end else if (take_jmp) begin
            pc_sel   = PC_SEL_JMP;
            fd_flush = 1'b1;
            dx_flush = 1'b1;
        end else if (take_ld) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_flush = 1'b1;
        end
    end

    // EX operand forwarding; MEM result is younger so it wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            if (XM_RegWrite && (XM_RD != REG_ZERO) && (XM_RD == DX_RS)) begin
                fwd_a = FWD_MEM;
            end else if (MW_RegWrite && (MW_RD != REG_ZERO) && (MW_RD == DX_RS)) begin
                fwd_a = FWD_WB;
            end
            if (XM_RegWrite && (XM_RD != REG_ZERO) && (XM_RD == DX_RT)) begin
                fwd_b = FWD_MEM;
            end else if (MW_RegWrite && (MW_RD != REG_ZERO) && (MW_RD == DX_RT)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Length of the wait run including the current cycle, saturating at 255
    always_comb begin
        if (state_q == StRun) begin
            wait_inc = 8'd1;
        end else if (wait_run_q == 8'hFF) begin
            wait_inc = 8'hFF;
        end else begin
            wait_inc = wait_run_q + 8'd1;
        end
    end

    // RUN/HOLD tracking of consecutive mem_wait cycles with sticky watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            wait_run_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_wait) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (!mem_wait) begin
                        state_q <= StRun;
                    end
                end
            endcase
            wait_run_q <= mem_wait ? wait_inc : 8'd0;
            if (mem_wait && (32'(wait_inc) >= MAX_WAIT)) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt_ldstall (
        .clk   (clk),
        .rst   (rst),
        .inc   (take_ld),
        .count (cnt_ldstall)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (take_br || take_jmp),
        .count (cnt_flush)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_cnt_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_wait),
        .count (cnt_wait)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Produces per-stage write enables, flushes, PC source select and EX operand-forwarding selects.
- Resolves load-use stalls, taken branches (resolved at EX, registered into XM), jumps (resolved in EX) and data-memory wait freezes.
- Keeps a HOLD state machine, a wait-timeout watchdog and saturating performance counters.

Parameters:
- CNT_W, 32: width of each performance counter.
- MAX_WAIT, 16: consecutive mem_wait cycles that trip timeout_err (legal range 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- FD_RS, FD_RT  in  5 each  source registers of the instruction in ID.
- FD_use_rt  in  1  the ID instruction reads rt as a source.
- DX_RS, DX_RT  in  5 each  source registers of the instruction in EX.
- DX_RD  in  5  destination of the instruction in EX.
- DX_MemRead  in  1  the instruction in EX is a load.
- DX_jump  in  1  the instruction in EX is a jump.
- XM_RD  in  5  destination register in MEM.
- XM_RegWrite  in  1  MEM instruction writes the register file.
- XM_branch  in  1  taken branch, registered at the end of EX.
- MW_RD  in  5  destination register in WB.
- MW_RegWrite  in  1  WB instruction writes the register file.
- mem_wait  in  1  data memory not ready.
- pc_we, fd_we, dx_we, xm_we, mw_we  out  1 each  pipeline register enables.
- fd_flush, dx_flush, xm_flush  out  1 each  load a bubble (all controls 0) on the next edge.
- pc_sel  out  2  00 = PC+4, 01 = branch target XM_BT, 10 = jump target JT.
- fwd_a, fwd_b  out  2 each  00 = register file, 01 = WB value, 10 = MEM ALUout.
- timeout_err  out  1  sticky watchdog flag.
- cnt_ldstall, cnt_flush, cnt_wait  out  CNT_W each  performance counters.

Behaviour:
- Reset (async): state=RUN, wait_run=0, timeout_err=0, all counters 0.
- While rst is high: all *_we=0, all flushes=0, pc_sel=00, fwd=00.
- Control outputs are combinational from the current inputs. Default: all we=1, flushes=0, pc_sel=00.
- Priority, highest first: mem_wait > branch > jump > load-use.
- Freeze (mem_wait=1, any state): all we=0, flushes=0, pc_sel=00.
  - Branch/jump flushes are deferred; XM_branch and DX_jump persist because the stages are frozen.
- Branch (XM_branch=1): pc_sel=01; fd_flush, dx_flush, xm_flush=1.
  - Jump and load-use conditions in the same cycle are ignored.
- Jump (DX_jump=1, no branch): pc_sel=10; fd_flush=1, dx_flush=1.
- Load-use: DX_MemRead=1, DX_RD!=0, and (DX_RD==FD_RS or (FD_use_rt and DX_RD==FD_RT)).
  - Response: pc_we=0, fd_we=0, dx_flush=1.
  - Exactly one bubble; the condition clears naturally the next cycle.
- Forwarding, fwd_a on DX_RS:
  - 10 if XM_RegWrite and XM_RD!=0 and XM_RD==DX_RS;
  - else 01 if MW_RegWrite and MW_RD!=0 and MW_RD==DX_RS;
  - else 00.
  - fwd_b is identical on DX_RT. MEM beats WB.
  - Forwarding is unaffected by freeze.
- FSM RUN/HOLD:
  - RUN to HOLD when mem_wait=1. HOLD to RUN when mem_wait=0.
  - wait_run (8-bit) counts consecutive mem_wait cycles. It loads 1 on entry and increments in HOLD while mem_wait=1. It clears to 0 when mem_wait=0.
  - timeout_err sets on the edge that closes the MAX_WAIT-th consecutive mem_wait cycle. It stays set until reset.
  - wait_run saturates at 255.
- Counters, all saturating at all-ones:
  - cnt_ldstall +1 per load-use bubble cycle actually issued (not when masked by freeze/branch/jump).
  - cnt_flush +1 per branch or jump redirect cycle.
  - cnt_wait +1 per mem_wait cycle.

Decomposition:
- Shared package (pipe_pkg): PC_SEL_* codes (00/01/10), FWD_* codes (RF=00, WB=01, MEM=10), FSM state encoding (RUN=0, HOLD=1), REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameter W; ports clk, rst, inc, count), instanced three times.
- Forwarding and priority logic stay inline.

Test Plan:
- Load-use: DX_MemRead=1, DX_RD=5, FD_RS=5 for one cycle -> pc_we=0, fd_we=0, dx_flush=1 that cycle; cnt_ldstall=1 after the edge; FD_RS=0 with DX_RD=0 -> no stall.
- Forwarding: XM_RegWrite=1, XM_RD=3, MW_RegWrite=1, MW_RD=3, DX_RS=3, DX_RT=3 -> fwd_a=10, fwd_b=10; clear XM_RegWrite -> 01/01; XM_RD=0 with DX_RS=0 -> 00.
- Branch plus load-use plus jump in the same cycle -> pc_sel=01, three flushes=1, no stall; cnt_flush=1, cnt_ldstall=0.
- Freeze over branch: mem_wait=1 for 3 cycles with XM_branch=1 -> all we=0, flushes=0, pc_sel=00. On the cycle mem_wait drops -> pc_sel=01 and flushes asserted; cnt_wait=3.
- Watchdog (MAX_WAIT=4): mem_wait high 3 cycles then low -> timeout_err=0. Later held 4 cycles -> timeout_err=1 after the 4th edge; stays 1 after mem_wait drops.
- Async reset mid-HOLD (mem_wait=1, timeout_err=1) -> state RUN, counters 0, timeout_err=0 immediately, without waiting for a clock edge.
